// File: rtl/sfifo_if.sv
// Handshake bundle between an sfifo and its user.
// With SFIFO_PEAK_EN defined the bundle also carries peak_clr / peak_count.
interface sfifo_if #(
    parameter int C_DATA_WIDTH = 72,
    parameter int C_ADDR_WIDTH = 4
);
    logic [C_DATA_WIDTH-1:0] wdata;
    logic                    wren;
    logic                    wfull;
    logic                    walmost_full;
    logic                    wrerr;
    logic [C_DATA_WIDTH-1:0] rdata;
    logic                    rden;
    logic                    rempty;
    logic                    ralmost_empty;
    logic                    rderr;
    logic [C_ADDR_WIDTH:0]   count;
`ifdef SFIFO_PEAK_EN
    logic                    peak_clr;
    logic [C_ADDR_WIDTH:0]   peak_count;

    modport master (
        output wdata, wren, rden, peak_clr,
        input  wfull, walmost_full, wrerr, rdata, rempty, ralmost_empty, rderr, count, peak_count
    );
    modport slave (
        input  wdata, wren, rden, peak_clr,
        output wfull, walmost_full, wrerr, rdata, rempty, ralmost_empty, rderr, count, peak_count
    );
`else
    modport master (
        output wdata, wren, rden,
        input  wfull, walmost_full, wrerr, rdata, rempty, ralmost_empty, rderr, count
    );
    modport slave (
        input  wdata, wren, rden,
        output wfull, walmost_full, wrerr, rdata, rempty, ralmost_empty, rderr, count
    );
`endif
endinterface

// File: rtl/sfifo.sv
// Single-clock FIFO with optional first-word-fall-through, almost flags, occupancy and error pulses.
// Optional high-water mark (peak_clr / peak_count) is built only when SFIFO_PEAK_EN is defined.
module sfifo #(
    parameter int C_DATA_WIDTH          = 72,
    parameter int C_ADDR_WIDTH          = 4,
    parameter int C_FWFT                = 1,
    parameter int C_ALMOST_FULL_OFFSET  = 4,
    parameter int C_ALMOST_EMPTY_OFFSET = 4
) (
    input  logic    clk,
    input  logic    rst,
    sfifo_if.slave  bus
);
    localparam int DEPTH = 2 ** C_ADDR_WIDTH;
    localparam logic [C_ADDR_WIDTH:0] ZERO_LVL = {(C_ADDR_WIDTH+1){1'b0}};
    localparam logic [C_ADDR_WIDTH:0] FULL_LVL = (C_ADDR_WIDTH+1)'(DEPTH);
    localparam logic [C_ADDR_WIDTH:0] AF_LVL   = (C_ADDR_WIDTH+1)'(DEPTH - C_ALMOST_FULL_OFFSET);
    localparam logic [C_ADDR_WIDTH:0] AE_LVL   = (C_ADDR_WIDTH+1)'(C_ALMOST_EMPTY_OFFSET);
    localparam logic                  AF_RST   = (C_ALMOST_FULL_OFFSET >= DEPTH);

    logic [C_DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [C_ADDR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [C_ADDR_WIDTH:0]   count_q, count_d;
    logic                    wfull_q, wfull_d, walmost_full_q, walmost_full_d;
    logic                    rempty_q, rempty_d, ralmost_empty_q, ralmost_empty_d;
    logic                    wrerr_q, wrerr_d, rderr_q, rderr_d;
    logic [C_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                    wr_acc, rd_acc;

    // Next-state pointers, occupancy, flags, error pulses and read data.
    always_comb begin
        wr_acc = bus.wren & ~wfull_q;
        rd_acc = bus.rden & ~rempty_q;

        if (wr_acc) wptr_d = wptr_q + 1'b1;
        else        wptr_d = wptr_q;
        if (rd_acc) rptr_d = rptr_q + 1'b1;
        else        rptr_d = rptr_q;

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        wfull_d         = (count_d == FULL_LVL);
        walmost_full_d  = (count_d >= AF_LVL);
        rempty_d        = (count_d == ZERO_LVL);
        ralmost_empty_d = (count_d <= AE_LVL);
        wrerr_d         = bus.wren & wfull_q;
        rderr_d         = bus.rden & rempty_q;

        // FWFT preloads the next head; a write landing on that slot is bypassed.
        if (C_FWFT != 0) begin
            if (count_d == ZERO_LVL)                rdata_d = rdata_q;
            else if (wr_acc && (wptr_q == rptr_d))  rdata_d = bus.wdata;
            else                                    rdata_d = mem_q[rptr_d];
        end else begin
            if (rd_acc) rdata_d = mem_q[rptr_q];
            else        rdata_d = rdata_q;
        end
    end

    // Storage array; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wptr_q] <= bus.wdata;
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q          <= {C_ADDR_WIDTH{1'b0}};
            rptr_q          <= {C_ADDR_WIDTH{1'b0}};
            count_q         <= ZERO_LVL;
            wfull_q         <= 1'b0;
            walmost_full_q  <= AF_RST;
            rempty_q        <= 1'b1;
            ralmost_empty_q <= 1'b1;
            wrerr_q         <= 1'b0;
            rderr_q         <= 1'b0;
            rdata_q         <= {C_DATA_WIDTH{1'b0}};
        end else begin
            wptr_q          <= wptr_d;
            rptr_q          <= rptr_d;
            count_q         <= count_d;
            wfull_q         <= wfull_d;
            walmost_full_q  <= walmost_full_d;
            rempty_q        <= rempty_d;
            ralmost_empty_q <= ralmost_empty_d;
            wrerr_q         <= wrerr_d;
            rderr_q         <= rderr_d;
            rdata_q         <= rdata_d;
        end
    end

    assign bus.wfull         = wfull_q;
    assign bus.walmost_full  = walmost_full_q;
    assign bus.wrerr         = wrerr_q;
    assign bus.rdata         = rdata_q;
    assign bus.rempty        = rempty_q;
    assign bus.ralmost_empty = ralmost_empty_q;
    assign bus.rderr         = rderr_q;
    assign bus.count         = count_q;

`ifdef SFIFO_PEAK_EN
    logic [C_ADDR_WIDTH:0] peak_q, peak_d;

    // High-water mark of the registered count; clear reloads the present count.
    always_comb begin
        if (bus.peak_clr)          peak_d = count_q;
        else if (count_q > peak_q) peak_d = count_q;
        else                       peak_d = peak_q;
    end

    // Peak register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) peak_q <= ZERO_LVL;
        else     peak_q <= peak_d;
    end

    assign bus.peak_count = peak_q;
`endif
endmodule

// File: tb/tb_sfifo.sv
// Randomised scoreboard bench for sfifo: a queue model tracks contents and flags,
// a negedge monitor compares DUT outputs and pops on every read handshake.
module tb_sfifo;
    localparam int DW    = 72;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sfifo_if #(.C_DATA_WIDTH(DW), .C_ADDR_WIDTH(AW)) bus0 ();
    sfifo #(.C_DATA_WIDTH(DW), .C_ADDR_WIDTH(AW), .C_FWFT(1),
            .C_ALMOST_FULL_OFFSET(4), .C_ALMOST_EMPTY_OFFSET(4))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));

    sfifo_if #(.C_DATA_WIDTH(8), .C_ADDR_WIDTH(2)) bus1 ();
    sfifo #(.C_DATA_WIDTH(8), .C_ADDR_WIDTH(2), .C_FWFT(0),
            .C_ALMOST_FULL_OFFSET(0), .C_ALMOST_EMPTY_OFFSET(0))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int pass_cnt = 0;
    int tot_cnt  = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: the expected contents in order, plus pending error pulses.
    logic [DW-1:0] expq[$];
    bit m_wrerr = 1'b0;
    bit m_rderr = 1'b0;

    always @(negedge clk) begin
        int  n;
        bit  wacc;
        if (rst) begin
            expq.delete();
            m_wrerr = 1'b0;
            m_rderr = 1'b0;
        end else begin
            n = expq.size();
            chk("count",         DW'(bus0.count),         DW'(n));
            chk("rempty",        DW'(bus0.rempty),        DW'(n == 0));
            chk("ralmost_empty", DW'(bus0.ralmost_empty), DW'(n <= 4));
            chk("wfull",         DW'(bus0.wfull),         DW'(n == DEPTH));
            chk("walmost_full",  DW'(bus0.walmost_full),  DW'(n >= DEPTH - 4));
            chk("wrerr",         DW'(bus0.wrerr),         DW'(m_wrerr));
            chk("rderr",         DW'(bus0.rderr),         DW'(m_rderr));
            wacc    = bus0.wren && (n < DEPTH);
            m_wrerr = bus0.wren && !wacc;
            m_rderr = bus0.rden && (n == 0);
            if (bus0.rden && !bus0.rempty) begin
                if (n == 0) chk("pop_underflow", DW'(1), DW'(0));
                else        chk("pop_data", bus0.rdata, expq.pop_front());
            end else if (n > 0) begin
                chk("head_data", bus0.rdata, expq[0]);
            end
            if (wacc) expq.push_back(bus0.wdata);
        end
    end

    task automatic drive(input bit w, input bit r, input logic [DW-1:0] d);
        bus0.wren  = w;
        bus0.rden  = r;
        bus0.wdata = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [95:0] r96;
        bus0.wren = 1'b0; bus0.rden = 1'b0; bus0.wdata = '0;
        bus1.wren = 1'b0; bus1.rden = 1'b0; bus1.wdata = 8'h00;
`ifdef SFIFO_PEAK_EN
        bus0.peak_clr = 1'b0;
        bus1.peak_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state after idling.
        repeat (5) drive(1'b0, 1'b0, '0);
        chk("rst_rdata", bus0.rdata, '0);
        chk("rst_rempty", DW'(bus0.rempty), DW'(1));

        // Standard read port: data valid after the rden edge and held.
        bus1.wdata = 8'h11; bus1.wren = 1'b1;
        drive(1'b0, 1'b0, '0);
        bus1.wren = 1'b0;
        chk("std_rempty_after_wr", DW'(bus1.rempty), DW'(0));
        chk("std_rdata_before_rd", DW'(bus1.rdata), DW'(8'h00));
        bus1.rden = 1'b1;
        drive(1'b0, 1'b0, '0);
        bus1.rden = 1'b0;
        chk("std_rdata", DW'(bus1.rdata), DW'(8'h11));
        chk("std_rempty_after_rd", DW'(bus1.rempty), DW'(1));
        repeat (3) drive(1'b0, 1'b0, '0);
        chk("std_rdata_hold", DW'(bus1.rdata), DW'(8'h11));

        // FWFT: first write visible one cycle after its edge.
        drive(1'b1, 1'b0, DW'(8'hA5));
        chk("fwft_first_rempty", DW'(bus0.rempty), DW'(0));
        chk("fwft_first_rdata", bus0.rdata, DW'(8'hA5));
        drive(1'b1, 1'b0, DW'(8'h5A));
        drive(1'b0, 1'b1, '0);
        chk("fwft_second_rdata", bus0.rdata, DW'(8'h5A));
        drive(1'b0, 1'b1, '0);
        chk("fwft_drained_count", DW'(bus0.count), DW'(0));

        // Fill to full, overflow attempt, then simultaneous op on full.
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, DW'(i));
        drive(1'b1, 1'b0, DW'(99));
        chk("ovf_wrerr", DW'(bus0.wrerr), DW'(1));
        chk("ovf_count", DW'(bus0.count), DW'(DEPTH));
        drive(1'b0, 1'b0, '0);
        chk("ovf_wrerr_clear", DW'(bus0.wrerr), DW'(0));
        drive(1'b1, 1'b1, DW'(77));
        chk("full_rw_count", DW'(bus0.count), DW'(DEPTH - 1));
        chk("full_rw_wrerr", DW'(bus0.wrerr), DW'(1));
        repeat (DEPTH - 1) drive(1'b0, 1'b1, '0);

        // Simultaneous op on empty.
        drive(1'b1, 1'b1, DW'(55));
        chk("empty_rw_count", DW'(bus0.count), DW'(1));
        chk("empty_rw_rderr", DW'(bus0.rderr), DW'(1));
        drive(1'b0, 1'b1, '0);

        // Steady state at 10 entries while pointers wrap.
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, DW'(100 + i));
        for (int i = 0; i < 40; i++) drive(1'b1, 1'b1, DW'(200 + i));
        chk("steady_count", DW'(bus0.count), DW'(10));
        repeat (10) drive(1'b0, 1'b1, '0);

        // Random traffic, write-heavy then read-heavy.
        for (int i = 0; i < 400; i++) begin
            r96 = {$urandom, $urandom, $urandom};
            if (i < 200) drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, r96[DW-1:0]);
            else         drive($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7, r96[DW-1:0]);
        end

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, DW'(300 + i));
        bus0.rden = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("arst_count", DW'(bus0.count), DW'(0));
        chk("arst_rempty", DW'(bus0.rempty), DW'(1));
        chk("arst_ralmost_empty", DW'(bus0.ralmost_empty), DW'(1));
        chk("arst_wfull", DW'(bus0.wfull), DW'(0));
        chk("arst_walmost_full", DW'(bus0.walmost_full), DW'(0));
        chk("arst_rdata", bus0.rdata, '0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) drive(1'b0, 1'b0, '0);

`ifdef SFIFO_PEAK_EN
        for (int i = 0; i < 9; i++) drive(1'b1, 1'b0, DW'(i));
        for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, '0);
        drive(1'b0, 1'b0, '0);
        chk("peak_hold", DW'(bus0.peak_count), DW'(9));
        bus0.peak_clr = 1'b1;
        drive(1'b0, 1'b0, '0);
        bus0.peak_clr = 1'b0;
        chk("peak_clr", DW'(bus0.peak_count), DW'(0));
`endif

        drive(1'b0, 1'b0, '0);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
